// File: rtl/gpio_pad_ctrl_pkg.sv
// gpio_pad_ctrl_pkg: register map and bus widths shared by the GPIO pad controller.
package gpio_pad_ctrl_pkg;

    localparam int GPIO_ADDR_W = 5;
    localparam int GPIO_DATA_W = 32;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR_OFS        = 5'h00;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT_OFS        = 5'h04;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IN_OFS         = 5'h08;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IRQ_EN_OFS     = 5'h0C;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IRQ_STATUS_OFS = 5'h10;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IRQ_RISE_OFS   = 5'h14;

endpackage

// File: rtl/gpio_pad_sync.sv
// gpio_pad_sync: one-pad 2-flop synchronizer for an asynchronous pad input.
// With GPIO_PAD_CTRL_DEBOUNCE_EN defined, a per-pad counter follows the
// synchronizer and the output only changes after the synchronized value has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
module gpio_pad_sync #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic in_o
);

    logic sync1_q;
    logic sync2_q;

    // Two-stage metastability synchronizer, cleared to 0 on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             in_q;
    logic             in_d;

    // Count consecutive cycles the synchronized value disagrees with the output
    always_comb begin
        cnt_d = cnt_q;
        in_d  = in_q;
        if (sync2_q == in_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d = {CNT_W{1'b0}};
            in_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce counter and debounced output state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
            in_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            in_q  <= in_d;
        end
    end

    assign in_o = in_q;
`else
    logic [31:0] unused_debounce;
    assign unused_debounce = 32'(DEBOUNCE_CYCLES);
    assign in_o = sync2_q;
`endif

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: APB-controlled GPIO for NUM_PADS bidirectional io_cell pads.
// Generates per-pad config (bit 0 = direction) and output value, samples the
// pad inputs through gpio_pad_sync, detects edges and raises a level irq.
// Optional input debounce is built when GPIO_PAD_CTRL_DEBOUNCE_EN is defined.
module gpio_pad_ctrl
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int NUM_PADS        = 8,
    parameter int CONF_WIDTH      = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [GPIO_ADDR_W-1:0]         paddr,
    input  logic [GPIO_DATA_W-1:0]         pwdata,
    output logic [GPIO_DATA_W-1:0]         prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_PADS*CONF_WIDTH-1:0] pad_cfg_o,
    output logic [NUM_PADS-1:0]            pad_out_o,
    input  logic [NUM_PADS-1:0]            pad_in_i,
    output logic                           irq_o
);

    logic [NUM_PADS-1:0] dir_q,    dir_d;
    logic [NUM_PADS-1:0] out_q,    out_d;
    logic [NUM_PADS-1:0] irq_en_q, irq_en_d;
    logic [NUM_PADS-1:0] status_q, status_d;
    logic [NUM_PADS-1:0] rise_q,   rise_d;
    logic [NUM_PADS-1:0] prev_q,   prev_d;
    logic                irq_q,    irq_d;

    logic [NUM_PADS-1:0]    in_sync;
    logic [NUM_PADS-1:0]    w1c_s;
    logic [NUM_PADS-1:0]    edge_s;
    logic [NUM_PADS-1:0]    status_set_s;
    logic                   access_s;
    logic                   wr_s;
    logic                   mapped_s;
    logic [GPIO_ADDR_W-1:0] ofs_s;
    logic                   unused_bus;

    // Zero-extend a pad vector onto the 32-bit read bus
    function automatic logic [GPIO_DATA_W-1:0] pad_ext(input logic [NUM_PADS-1:0] v);
        logic [GPIO_DATA_W-1:0] r;
        r = '0;
        r[NUM_PADS-1:0] = v;
        return r;
    endfunction

    assign unused_bus = ^{paddr[1:0], pwdata};

    genvar g;
    generate
        for (g = 0; g < NUM_PADS; g++) begin : g_sync
            gpio_pad_sync #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_sync (
                .clk  (clk),
                .rst  (rst),
                .pad_i(pad_in_i[g]),
                .in_o (in_sync[g])
            );
        end
    endgenerate

    assign access_s = psel & penable;
    assign wr_s     = access_s & pwrite;
    assign ofs_s    = {paddr[4:2], 2'b00};
    assign mapped_s = (ofs_s <= GPIO_IRQ_RISE_OFS);

    // Register writes, edge detection and status/irq next-state
    always_comb begin
        dir_d    = dir_q;
        out_d    = out_q;
        irq_en_d = irq_en_q;
        rise_d   = rise_q;
        w1c_s    = '0;
        if (wr_s) begin
            case (ofs_s)
                GPIO_DIR_OFS:        dir_d    = pwdata[NUM_PADS-1:0];
                GPIO_OUT_OFS:        out_d    = pwdata[NUM_PADS-1:0];
                GPIO_IRQ_EN_OFS:     irq_en_d = pwdata[NUM_PADS-1:0];
                GPIO_IRQ_STATUS_OFS: w1c_s    = pwdata[NUM_PADS-1:0];
                GPIO_IRQ_RISE_OFS:   rise_d   = pwdata[NUM_PADS-1:0];
                default:             ;
            endcase
        end else begin
            w1c_s = '0;
        end
        edge_s = (rise_q & in_sync & ~prev_q) | (~rise_q & ~in_sync & prev_q);
        // A pad leaving or entering output mode this cycle must not latch an edge
        status_set_s = edge_s & dir_q & dir_d;
        // New edges take priority over a same-cycle clear
        status_d = (status_q & ~w1c_s) | status_set_s;
        prev_d   = in_sync;
        irq_d    = |(status_q & irq_en_q);
    end

    // Register file and interrupt state; pads return to high-Z on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q    <= '1;
            out_q    <= '0;
            irq_en_q <= '0;
            status_q <= '0;
            rise_q   <= '0;
            prev_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            out_q    <= out_d;
            irq_en_q <= irq_en_d;
            status_q <= status_d;
            rise_q   <= rise_d;
            prev_q   <= prev_d;
            irq_q    <= irq_d;
        end
    end

    // Combinational read mux and error response during the access phase
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access_s && !mapped_s) begin
            pslverr = 1'b1;
        end else if (access_s && !pwrite) begin
            case (ofs_s)
                GPIO_DIR_OFS:        prdata = pad_ext(dir_q);
                GPIO_OUT_OFS:        prdata = pad_ext(out_q);
                GPIO_IN_OFS:         prdata = pad_ext(in_sync);
                GPIO_IRQ_EN_OFS:     prdata = pad_ext(irq_en_q);
                GPIO_IRQ_STATUS_OFS: prdata = pad_ext(status_q);
                GPIO_IRQ_RISE_OFS:   prdata = pad_ext(rise_q);
                default:             prdata = '0;
            endcase
        end else begin
            prdata = '0;
        end
    end

    // Pad config: direction in bit 0 of each slice, other bits held low
    always_comb begin
        pad_cfg_o = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            pad_cfg_o[i*CONF_WIDTH] = dir_q[i];
        end
    end

    assign pad_out_o = out_q;
    assign pready    = 1'b1;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: directed self-checking bench for gpio_pad_ctrl.
module tb_gpio_pad_ctrl;
    import gpio_pad_ctrl_pkg::*;

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    localparam int DBC = 4;
`else
    localparam int DBC = 0;
`endif
    localparam int LAT = 2 + DBC;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [23:0] pad_cfg_o;
    logic [7:0]  pad_out_o;
    logic [7:0]  pad_in_i;
    logic        irq_o;

    int tests  = 0;
    int failed = 0;

    logic [31:0] rd;
    logic        er;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(
        .NUM_PADS(8),
        .CONF_WIDTH(3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .pad_cfg_o(pad_cfg_o), .pad_out_o(pad_out_o),
        .pad_in_i(pad_in_i), .irq_o(irq_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 e = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; e = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 5'h00; pwdata = 32'h0; pad_in_i = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Reset state
        #1;
        check("rst_cfg",    32'(pad_cfg_o), 32'h0024_9249);
        check("rst_out",    32'(pad_out_o), 32'h0);
        check("rst_irq",    32'(irq_o),     32'h0);
        check("rst_pready", 32'(pready),    32'h1);
        check("rst_prdata", prdata,         32'h0);
        check("rst_slverr", 32'(pslverr),   32'h0);
        apb_read(GPIO_DIR_OFS, rd, er);
        check("rd_dir_rst", rd, 32'h0000_00FF);
        check("rd_dir_err", 32'(er), 32'h0);

        // Direction and output drive
        apb_write(GPIO_DIR_OFS, 32'hFFFF_FFFE, er);
        check("cfg_pad0_out", 32'(pad_cfg_o), 32'h0024_9248);
        apb_write(GPIO_OUT_OFS, 32'h0000_0001, er);
        check("pad_out", 32'(pad_out_o), 32'h0000_0001);
        apb_read(GPIO_DIR_OFS, rd, er);
        check("rd_dir", rd, 32'h0000_00FE);
        apb_read(GPIO_OUT_OFS, rd, er);
        check("rd_out", rd, 32'h0000_0001);

        // Rising edge on pad 3 through IN, STATUS and irq
        apb_write(GPIO_IRQ_EN_OFS,   32'h08, er);
        apb_write(GPIO_IRQ_RISE_OFS, 32'h08, er);
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = GPIO_IN_OFS;
        pad_in_i[3] = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        #1 check("in_early", prdata, 32'h0);
        @(negedge clk);
        #1 check("in_set", prdata, 32'h08);
        paddr = GPIO_IRQ_STATUS_OFS;
        #1 check("sts_early", prdata, 32'h0);
        @(negedge clk);
        #1 check("sts_set", prdata, 32'h08);
        check("irq_early", 32'(irq_o), 32'h0);
        @(negedge clk);
        #1 check("irq_set", 32'(irq_o), 32'h1);
        psel = 1'b0; penable = 1'b0;
        apb_write(GPIO_IRQ_STATUS_OFS, 32'h08, er);
        check("irq_hold", 32'(irq_o), 32'h1);
        @(posedge clk);
        #1 check("irq_clr", 32'(irq_o), 32'h0);
        apb_read(GPIO_IRQ_STATUS_OFS, rd, er);
        check("sts_clr", rd, 32'h0);

        // Same-cycle W1C and new edge on pad 4: set wins
        apb_write(GPIO_IRQ_RISE_OFS, 32'h18, er);
        @(negedge clk);
        pad_in_i[4] = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        apb_write(GPIO_IRQ_STATUS_OFS, 32'h10, er);
        apb_read(GPIO_IRQ_STATUS_OFS, rd, er);
        check("set_wins", rd, 32'h10);
        check("irq_masked", 32'(irq_o), 32'h0);
        apb_write(GPIO_IRQ_STATUS_OFS, 32'h10, er);
        apb_read(GPIO_IRQ_STATUS_OFS, rd, er);
        check("sts_clr4", rd, 32'h0);

        // Falling edges: pad 5 in output mode ignored, pad 6 in input mode captured
        apb_write(GPIO_DIR_OFS, 32'hDE, er);
        check("cfg_pad5_out", 32'(pad_cfg_o), 32'h0024_1248);
        apb_write(GPIO_IRQ_RISE_OFS, 32'h00, er);
        @(negedge clk);
        pad_in_i[5] = 1'b1; pad_in_i[6] = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        pad_in_i[5] = 1'b0; pad_in_i[6] = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        apb_read(GPIO_IRQ_STATUS_OFS, rd, er);
        check("fall_sts", rd, 32'h40);
        check("fall_irq", 32'(irq_o), 32'h0);
        apb_write(GPIO_IRQ_STATUS_OFS, 32'h40, er);

        // Unmapped access and write to IN
        apb_read(5'h18, rd, er);
        check("unmap_rd_err", 32'(er), 32'h1);
        check("unmap_rd_data", rd, 32'h0);
        apb_write(5'h18, 32'h0, er);
        check("unmap_wr_err", 32'(er), 32'h1);
        apb_read(GPIO_DIR_OFS, rd, er);
        check("unmap_dir", rd, 32'hDE);
        apb_read(GPIO_OUT_OFS, rd, er);
        check("unmap_out", rd, 32'h01);
        apb_read(GPIO_IRQ_EN_OFS, rd, er);
        check("unmap_en", rd, 32'h08);
        apb_write(GPIO_IN_OFS, 32'hFF, er);
        check("in_wr_err", 32'(er), 32'h0);
        apb_read(GPIO_IN_OFS, rd, er);
        check("in_wr_ign", rd, 32'h18);

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_cfg", 32'(pad_cfg_o), 32'h0024_9249);
        check("arst_out", 32'(pad_out_o), 32'h0);
        @(negedge clk) rst = 1'b0;
        apb_read(GPIO_DIR_OFS, rd, er);
        check("arst_dir", rd, 32'hFF);

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
        // Debounce: short glitch filtered, longer pulse accepted
        pad_in_i = 8'h00;
        repeat (LAT + 4) @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = GPIO_IN_OFS;
        pad_in_i[1] = 1'b1;
        repeat (3) @(negedge clk);
        pad_in_i[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1 check("glitch", prdata, 32'h0);
        end
        @(negedge clk);
        pad_in_i[1] = 1'b1;
        repeat (5) @(negedge clk);
        #1 check("pulse_early", prdata, 32'h0);
        @(negedge clk);
        #1 check("pulse_in", prdata, 32'h02);
        pad_in_i[1] = 1'b0;
        psel = 1'b0; penable = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
